// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program
// counter, issues word fetches over a req/ack handshake that tolerates wait
// states, and buffers returned words in a 2-entry queue. The queue head
// (instruction and its PC+4) feeds the IF/ID stage register.
//
// Ports:
//   clk           pipeline clock, all state updates on the rising edge
//   rstN          asynchronous active-low reset
//   stall         hazard hold: the head entry is not consumed this cycle
//   redirect      taken branch/jump; outranks stall
//   redirectPC    new fetch target (bits [1:0] ignored)
//   imemReq       fetch request (combinational)
//   imemAddr      fetch address, stable while a request waits for ack
//   imemAck       memory completion, imemData valid in the same cycle
//   imemData      fetched word
//   ifValid       queue head valid
//   ifInstruction head instruction, 0 when empty
//   ifNewPC       head PC+4, 0 when empty
//   flush         redirect | ~ifValid: bubble insert for the ID register
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic        ifValid,
  output logic [31:0] ifInstruction,
  output logic [31:0] ifNewPC,
  output logic        flush
);

  // RUN: normal fetching from pc_reg.
  // DROP: a fetch was in flight when a redirect arrived; keep the bus
  // transaction alive at its original address and throw its data away.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

  localparam int DEPTH = 2;

  logic [0:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] drop_addr_reg, drop_addr_next;
  logic [1:0]  count_reg, count_next;

  // Queue storage. Entry 0 is always the head; a pop shifts entry 1 down.
  logic [31:0] instr_reg [DEPTH];
  logic [31:0] npc_reg   [DEPTH];
  logic [31:0] instr_next [DEPTH];
  logic [31:0] npc_next   [DEPTH];

  logic        push;
  logic        pop;
  logic [1:0]  fill_after_pop;
  logic [0:0]  wr_idx;
  logic [31:0] pc_plus4;
  logic [31:0] target_pc;
  logic        redirect_pc_unused;

  assign pc_plus4  = pc_reg + 32'd4;      // wraps mod 2^32
  assign target_pc = {redirectPC[31:2], 2'b00};
  assign redirect_pc_unused = ^redirectPC[1:0];

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ifValid       = (count_reg != 2'd0);
  assign ifInstruction = ifValid ? instr_reg[0] : 32'd0;
  assign ifNewPC       = ifValid ? npc_reg[0]   : 32'd0;
  assign flush         = redirect | ~ifValid;

  // In RUN the request tracks free queue space. Once raised it cannot drop
  // before ack: the queue only grows on an ack, and a pop only frees space.
  assign imemReq  = (state_reg == ST_DROP) || (count_reg < 2'd2);
  assign imemAddr = (state_reg == ST_DROP) ? drop_addr_reg : pc_reg;

  // -------------------------------------------------------------------------
  // Queue control
  // -------------------------------------------------------------------------
  assign push = (state_reg == ST_RUN) & imemReq & imemAck & ~redirect;
  assign pop  = ifValid & ~stall & ~redirect;

  // A simultaneous pop frees the head slot first, so the new word lands at
  // the first free index after the shift.
  assign fill_after_pop = count_reg - {1'b0, pop};
  assign wr_idx         = fill_after_pop[0];

  always_comb begin
    count_next = fill_after_pop + {1'b0, push};
    if (redirect) begin
      count_next = 2'd0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic        load;
      logic [31:0] shift_instr;
      logic [31:0] shift_npc;

      if (gi < DEPTH - 1) begin : g_shift
        assign shift_instr = instr_reg[gi+1];
        assign shift_npc   = npc_reg[gi+1];
      end else begin : g_tail
        // The tail slot becomes free on a pop; its stale contents are
        // masked by count_reg and never observed.
        assign shift_instr = instr_reg[gi];
        assign shift_npc   = npc_reg[gi];
      end

      assign load = push && (wr_idx == 1'(gi));

      assign instr_next[gi] = load ? imemData :
                              (pop ? shift_instr : instr_reg[gi]);
      assign npc_next[gi]   = load ? pc_plus4 :
                              (pop ? shift_npc : npc_reg[gi]);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // PC / FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;

    if (redirect) begin
      pc_next = target_pc;
      if (imemReq && !imemAck) begin
        // The in-flight transfer must complete at its original address.
        // In DROP imemAddr already equals drop_addr_reg, so this holds it.
        state_next     = ST_DROP;
        drop_addr_next = imemAddr;
      end else begin
        // Either nothing outstanding or it completes now: data discarded.
        state_next = ST_RUN;
      end
    end else if (state_reg == ST_DROP) begin
      if (imemAck) begin
        state_next = ST_RUN;
      end
    end else if (push) begin
      pc_next = pc_plus4;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg     <= ST_RUN;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= 32'd0;
      count_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
      count_reg     <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_reg[i] <= 32'd0;
        npc_reg[i]   <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_reg[i] <= instr_next[i];
        npc_reg[i]   <= npc_next[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit against a behavioural instruction memory with
// configurable (fixed or random) wait states, and compares every output on
// every cycle with a queue-based reference model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = 32'd0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        ifValid;
  logic [31:0] ifInstruction;
  logic [31:0] ifNewPC;
  logic        flush;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .stall        (stall),
    .redirect     (redirect),
    .redirectPC   (redirectPC),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .ifValid      (ifValid),
    .ifInstruction(ifInstruction),
    .ifNewPC      (ifNewPC),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // -------------------------------------------------------------------------
  // Instruction memory: word content is a scramble of the address so that a
  // data word can never be confused with its own address or PC+4.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  int wait_cfg = 0;   // >=0: fixed wait states, <0: random 0..3 per fetch
  int wcnt = 0;
  int cur_wait = 0;

  function automatic int pick_wait(input int cfg);
    return (cfg >= 0) ? cfg : int'($urandom_range(0, 3));
  endfunction

  always_comb begin
    imemAck  = rstN && imemReq && (wcnt == cur_wait);
    imemData = imemAck ? mem_word(imemAddr) : 32'd0;
  end

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wcnt     <= 0;
      cur_wait <= pick_wait(wait_cfg);
    end else if (imemAck) begin
      wcnt     <= 0;
      cur_wait <= pick_wait(wait_cfg);
    end else if (imemReq) begin
      wcnt     <= wcnt + 1;
    end
  end

  // -------------------------------------------------------------------------
  // Reference model: a plain queue of {instr, pc+4}, the next fetch pc, and
  // whether an abandoned fetch is still being drained.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_drop_addr = 32'd0;
  bit          m_drop = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_pc        = RESET_PC;
    m_drop      = 1'b0;
    m_drop_addr = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        e_valid;
    logic        e_req;
    logic        e_flush;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic [31:0] e_addr;
    e_valid = (m_q.size() != 0);
    e_instr = e_valid ? m_q[0].instr : 32'd0;
    e_npc   = e_valid ? m_q[0].npc   : 32'd0;
    e_req   = m_drop || (m_q.size() < 2);
    e_addr  = m_drop ? m_drop_addr : m_pc;
    e_flush = redirect || !e_valid;
    chk("ifValid",       {31'd0, ifValid}, {31'd0, e_valid});
    chk("ifInstruction", ifInstruction,    e_instr);
    chk("ifNewPC",       ifNewPC,          e_npc);
    chk("imemReq",       {31'd0, imemReq}, {31'd0, e_req});
    chk("imemAddr",      imemAddr,         e_addr);
    chk("flush",         {31'd0, flush},   {31'd0, e_flush});
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_update();
    bit     req_m;
    bit     consume;
    entry_t e;
    req_m   = m_drop || (m_q.size() < 2);
    consume = (m_q.size() != 0) && !stall && !redirect;
    if (redirect) begin
      if (req_m && !imemAck) begin
        if (!m_drop) m_drop_addr = m_pc;
        m_drop = 1'b1;
      end else begin
        m_drop = 1'b0;
      end
      m_q.delete();
      m_pc = {redirectPC[31:2], 2'b00};
    end else begin
      if (consume) void'(m_q.pop_front());
      if (m_drop) begin
        if (imemAck) m_drop = 1'b0;
      end else if (imemAck && req_m) begin
        e.instr = mem_word(m_pc);
        e.npc   = m_pc + 32'd4;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One cycle: drive inputs at the falling edge, check, advance the model.
  task automatic step(input bit s, input bit r, input logic [31:0] rpc);
    stall      = s;
    redirect   = r;
    redirectPC = rpc;
    #1;
    check_outputs();
    if (rstN) model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    rstN = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Directed and random sequence
  // -------------------------------------------------------------------------
  initial begin
    bit          found;
    logic [31:0] rpc;
    @(negedge clk);

    // Zero-wait streaming from reset.
    wait_cfg = 0;
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0);

    // Stall 4 cycles: queue fills to 2, request drops, resumes cleanly.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // Wait-state memory: 3 waits per fetch.
    wait_cfg = 3;
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'd0);

    // Redirect in the 2nd wait cycle of the fetch at 0x3008.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!m_drop && m_pc == 32'h0000_3008 && wcnt == 1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'd0);
    end
    chk("align_fetch_3008", {31'd0, found}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_3100);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'd0);

    // Redirect together with stall, misaligned target.
    step(1'b1, 1'b1, 32'h0000_3102);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0);

    // PC wrap at the top of the address space.
    wait_cfg = 0;
    do_reset();
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hFFFF_FFF4);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0);

    // Asynchronous reset in the middle of a pending wait.
    wait_cfg = 3;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);
    stall    = 1'b0;
    redirect = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    chk("async_ifValid",  {31'd0, ifValid}, 32'd0);
    chk("async_imemAddr", imemAddr,         RESET_PC);
    chk("async_imemReq",  {31'd0, imemReq}, 32'd1);
    chk("async_flush",    {31'd0, flush},   32'd1);
    chk("async_ifNewPC",  ifNewPC,          32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step(1'b0, 1'b0, 32'd0);
    rstN = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'd0);

    // Random stalls, redirects and wait states.
    wait_cfg = -1;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        rpc = 32'h0000_3000 + 32'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
